// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-through, no-write-allocate data cache
// Read misses refill a whole line word 0 upward; flush invalidates every line.
module dcache_dm #(
   parameter int ADDR_WIDTH = 17,
   parameter int INDEX_BITS = 6,
   parameter int LINE_WORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [1:0]            cpu_sel,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic [31:0]           cpu_rdata,
   output logic                  cpu_ready,
   input  logic                  flush,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [1:0]            mem_sel,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   input  logic                  mem_ack
);

   localparam int WORD_BITS = $clog2(LINE_WORDS);
   localparam int OFF_BITS  = WORD_BITS + 2;
   localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - INDEX_BITS;
   localparam int LINES     = 1 << INDEX_BITS;
   localparam int DEPTH     = LINES * LINE_WORDS;
   localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_REFILL = 2'd1,
      S_WRITE  = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [WORD_BITS-1:0]    beat_q, beat_d;
   logic                    pending_flush_q, pending_flush_d;
   logic [LINES-1:0]        valid_q;
   logic [TAG_BITS-1:0]     tag_q [LINES];
   logic [31:0]             data_q [DEPTH];

   logic                    mem_req_q, mem_req_d;
   logic                    mem_we_q, mem_we_d;
   logic [1:0]              mem_sel_q, mem_sel_d;
   logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]             mem_wdata_q, mem_wdata_d;
   logic [31:0]             cpu_rdata_q, cpu_rdata_d;
   logic                    cpu_ready_q, cpu_ready_d;
   logic [31:0]             crit_q, crit_d;

   logic [INDEX_BITS-1:0]   idx;
   logic [TAG_BITS-1:0]     tag;
   logic [WORD_BITS-1:0]    word;
   logic [WORD_BITS-1:0]    beat_nxt;
   logic                    hit;
   logic                    ack;
   logic [31:0]             cached_word;
   logic [3:0]              lane_en;
   logic [31:0]             lane_data;
   logic [31:0]             merged_word;

   logic                    flush_all;
   logic                    line_inval;
   logic                    refill_we;
   logic                    refill_done;
   logic                    write_hit_we;

   assign idx         = cpu_addr[OFF_BITS +: INDEX_BITS];
   assign tag         = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
   assign word        = cpu_addr[2 +: WORD_BITS];
   assign beat_nxt    = beat_q + WORD_BITS'(1);
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);
   assign ack         = mem_ack && mem_req_q;
   assign cached_word = data_q[{idx, word}];

   // Store lanes: misaligned half/word accesses simply drop the low address bits.
   always_comb begin
      lane_en   = 4'b0000;
      lane_data = cpu_wdata;
      case (cpu_sel)
         2'b01: begin
            lane_en   = 4'b0001 << cpu_addr[1:0];
            lane_data = {4{cpu_wdata[7:0]}};
         end
         2'b10: begin
            lane_en   = cpu_addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{cpu_wdata[15:0]}};
         end
         2'b11: begin
            lane_en   = 4'b1111;
            lane_data = cpu_wdata;
         end
         default: begin
            lane_en   = 4'b0000;
            lane_data = cpu_wdata;
         end
      endcase
      merged_word = cached_word;
      for (int i = 0; i < 4; i++) begin
         if (lane_en[i]) merged_word[8*i +: 8] = lane_data[8*i +: 8];
      end
   end

   always_comb begin
      state_d         = state_q;
      beat_d          = beat_q;
      pending_flush_d = pending_flush_q;
      mem_req_d       = mem_req_q;
      mem_we_d        = mem_we_q;
      mem_sel_d       = mem_sel_q;
      mem_addr_d      = mem_addr_q;
      mem_wdata_d     = mem_wdata_q;
      cpu_rdata_d     = cpu_rdata_q;
      cpu_ready_d     = 1'b0;
      crit_d          = crit_q;
      flush_all       = 1'b0;
      line_inval      = 1'b0;
      refill_we       = 1'b0;
      refill_done     = 1'b0;
      write_hit_we    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (flush || pending_flush_q) begin
               flush_all       = 1'b1;
               pending_flush_d = 1'b0;
            end else if (cpu_req) begin
               if (cpu_we) begin
                  state_d     = S_WRITE;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_sel_d   = cpu_sel;
                  mem_addr_d  = cpu_addr;
                  mem_wdata_d = cpu_wdata;
               end else if (hit) begin
                  state_d     = S_RESP;
                  cpu_ready_d = 1'b1;
                  cpu_rdata_d = cached_word;
               end else begin
                  // The victim line is invalid while it is being overwritten.
                  state_d     = S_REFILL;
                  beat_d      = '0;
                  line_inval  = 1'b1;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_sel_d   = 2'b11;
                  mem_addr_d  = {cpu_addr[ADDR_WIDTH-1:OFF_BITS], {WORD_BITS{1'b0}}, 2'b00};
               end
            end
         end
         S_REFILL: begin
            if (flush) pending_flush_d = 1'b1;
            if (ack) begin
               refill_we = 1'b1;
               if (beat_q == word) crit_d = mem_rdata;
               if (beat_q == LAST_BEAT) begin
                  refill_done = 1'b1;
                  state_d     = S_RESP;
                  cpu_ready_d = 1'b1;
                  cpu_rdata_d = (beat_q == word) ? mem_rdata : crit_q;
                  mem_req_d   = 1'b0;
                  mem_sel_d   = 2'b00;
                  mem_addr_d  = '0;
               end else begin
                  beat_d     = beat_nxt;
                  mem_addr_d = {cpu_addr[ADDR_WIDTH-1:OFF_BITS], beat_nxt, 2'b00};
               end
            end
         end
         S_WRITE: begin
            if (flush) pending_flush_d = 1'b1;
            if (ack) begin
               write_hit_we = hit;
               state_d      = S_RESP;
               cpu_ready_d  = 1'b1;
               mem_req_d    = 1'b0;
               mem_we_d     = 1'b0;
               mem_sel_d    = 2'b00;
               mem_addr_d   = '0;
               mem_wdata_d  = '0;
            end
         end
         S_RESP: begin
            if (flush) pending_flush_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         beat_q          <= '0;
         pending_flush_q <= 1'b0;
         valid_q         <= '0;
         mem_req_q       <= 1'b0;
         mem_we_q        <= 1'b0;
         mem_sel_q       <= 2'b00;
         mem_addr_q      <= '0;
         mem_wdata_q     <= '0;
         cpu_rdata_q     <= '0;
         cpu_ready_q     <= 1'b0;
         crit_q          <= '0;
      end else begin
         state_q         <= state_d;
         beat_q          <= beat_d;
         pending_flush_q <= pending_flush_d;
         mem_req_q       <= mem_req_d;
         mem_we_q        <= mem_we_d;
         mem_sel_q       <= mem_sel_d;
         mem_addr_q      <= mem_addr_d;
         mem_wdata_q     <= mem_wdata_d;
         cpu_rdata_q     <= cpu_rdata_d;
         cpu_ready_q     <= cpu_ready_d;
         crit_q          <= crit_d;
         if (flush_all) begin
            valid_q <= '0;
         end else if (line_inval) begin
            valid_q[idx] <= 1'b0;
         end else if (refill_done) begin
            valid_q[idx] <= 1'b1;
         end
      end
   end

   // Tag/data arrays need no reset: valid_q gates every use of them.
   always_ff @(posedge clk) begin
      if (refill_we) data_q[{idx, beat_q}] <= mem_rdata;
      if (write_hit_we) data_q[{idx, word}] <= merged_word;
      if (refill_done) tag_q[idx] <= tag;
   end

   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ready = cpu_ready_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_sel   = mem_sel_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dcache_dm.sv
// tb/tb_dcache_dm.sv - scoreboard bench for dcache_dm with a line-level cache model
// Memory returns 0xA0000000|addr; ack arrives on the second cycle of each request.
module tb_dcache_dm;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, flush;
   logic [1:0]  cpu_sel;
   logic [16:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_ready;
   logic        mem_req, mem_we;
   logic [1:0]  mem_sel;
   logic [16:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   dcache_dm #(.ADDR_WIDTH(17), .INDEX_BITS(6), .LINE_WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_sel(cpu_sel), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
      .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [16:0] addr;
      logic        we;
      logic [1:0]  sel;
      logic [31:0] wdata;
   } mem_t;

   typedef struct {
      logic        is_read;
      logic [31:0] rdata;
   } resp_t;

   mem_t  mem_exp[$];
   resp_t resp_exp[$];

   int errors = 0;
   int checks = 0;
   int ack_cnt = 0;

   logic        m_valid [64];
   logic [6:0]  m_tag   [64];
   logic [31:0] m_data  [64][4];
   logic        m_pend;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [16:0] a);
      return 32'hA000_0000 | {15'd0, a};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
   endtask

   // Memory responder plus checking of every memory access against expectations.
   initial begin
      int wcnt;
      mem_t e;
      wcnt = 0;
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            mem_ack = 1'b0;
            wcnt = 0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
            ack_cnt++;
         end else if (mem_req) begin
            wcnt++;
            if (wcnt == 2) begin
               if (mem_exp.size() == 0) begin
                  check("mem_unexpected", {15'd0, mem_addr}, 32'hFFFF_FFFF);
               end else begin
                  e = mem_exp.pop_front();
                  check("mem_addr", {15'd0, mem_addr}, {15'd0, e.addr});
                  check("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                  check("mem_sel", {30'd0, mem_sel}, {30'd0, e.sel});
                  if (e.we) check("mem_wdata", mem_wdata, e.wdata);
               end
               mem_rdata = mem_we ? 32'h0 : mem_val(mem_addr);
               mem_ack = 1'b1;
            end
         end
      end
   end

   // Response monitor.
   initial begin
      resp_t r;
      forever begin
         @(negedge clk);
         if (!rst && cpu_ready) begin
            if (resp_exp.size() == 0) begin
               check("resp_unexpected", 32'd1, 32'd0);
            end else begin
               r = resp_exp.pop_front();
               if (r.is_read) check("cpu_rdata", cpu_rdata, r.rdata);
            end
         end
      end
   end

   task automatic do_op(input logic we, input logic [1:0] sel, input logic [16:0] a,
                        input logic [31:0] wd, input int flush_at, output logic [31:0] rd);
      int idx, w, beats, lat, n, start_acks, lane;
      logic [6:0] tg;
      logic [16:0] base;
      logic [31:0] wv;
      logic got;
      resp_t r;
      mem_t m;
      lat = 0;
      if (m_pend) begin
         model_clear();
         m_pend = 1'b0;
         lat = 1;
      end
      idx  = int'(a[9:4]);
      w    = int'(a[3:2]);
      tg   = a[16:10];
      base = {a[16:4], 4'b0000};
      if (!we) begin
         if (m_valid[idx] && m_tag[idx] == tg) begin
            beats = 0;
            lat += 1;
         end else begin
            beats = 4;
            lat += 12;
            for (int k = 0; k < 4; k++) begin
               m.addr = base + 17'(4 * k); m.we = 1'b0; m.sel = 2'b11; m.wdata = '0;
               mem_exp.push_back(m);
               m_data[idx][k] = mem_val(m.addr);
            end
            m_valid[idx] = 1'b1;
            m_tag[idx] = tg;
         end
         r.is_read = 1'b1;
         r.rdata = m_data[idx][w];
      end else begin
         m.addr = a; m.we = 1'b1; m.sel = sel; m.wdata = wd;
         mem_exp.push_back(m);
         beats = 1;
         lat += 3;
         if (m_valid[idx] && m_tag[idx] == tg) begin
            wv = m_data[idx][w];
            if (sel == 2'b01) begin
               lane = int'(a[1:0]);
               wv[lane*8 +: 8] = wd[7:0];
            end else if (sel == 2'b10) begin
               lane = a[1] ? 2 : 0;
               wv[lane*8 +: 16] = wd[15:0];
            end else begin
               wv = wd;
            end
            m_data[idx][w] = wv;
         end
         r.is_read = 1'b0;
         r.rdata = '0;
      end
      resp_exp.push_back(r);

      start_acks = ack_cnt;
      cpu_we = we; cpu_sel = sel; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
      n = 0;
      got = 1'b0;
      while (!got && n < 400) begin
         @(posedge clk); #1;
         n++;
         flush = (flush_at != 0 && n == flush_at);
         if (cpu_ready) got = 1'b1;
      end
      flush = 1'b0;
      cpu_req = 1'b0;
      rd = cpu_rdata;
      check("op_done", {31'd0, got}, 32'd1);
      check("latency", n, lat);
      if (flush_at != 0) m_pend = 1'b1;
      @(posedge clk); #1;
      check("ready_pulse", {31'd0, cpu_ready}, 32'd0);
      check("mem_beats", ack_cnt - start_acks, beats);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      model_clear();
      m_pend = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic [16:0] a;
      logic        we;
      logic [1:0]  sel;
      int n, start_acks;
      mem_t m;

      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_sel = 2'b11; cpu_addr = '0; cpu_wdata = '0; flush = 0;
      model_clear();
      m_pend = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_cpu_rdata", cpu_rdata, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op(1'b0, 2'b11, 17'h00104, 32'h0, 0, rd);
      check("t1_rdata", rd, 32'hA000_0104);
      do_op(1'b0, 2'b11, 17'h00104, 32'h0, 0, rd);
      check("t2_hit_rdata", rd, 32'hA000_0104);
      do_op(1'b1, 2'b01, 17'h00105, 32'h0000_00EE, 0, rd);
      do_op(1'b0, 2'b11, 17'h00104, 32'h0, 0, rd);
      check("t3_merge", rd, 32'hA000_EE04);
      do_op(1'b0, 2'b11, 17'h00504, 32'h0, 0, rd);
      check("t4_evict", rd, 32'hA000_0504);
      do_op(1'b0, 2'b11, 17'h00104, 32'h0, 0, rd);
      check("t4_refill", rd, 32'hA000_0104);
      do_op(1'b1, 2'b11, 17'h00200, 32'h1234_5678, 0, rd);
      do_op(1'b0, 2'b11, 17'h00200, 32'h0, 0, rd);
      check("t5_no_alloc", rd, 32'hA000_0200);
      do_op(1'b0, 2'b11, 17'h00300, 32'h0, 2, rd);
      check("t6_flush_resp", rd, 32'hA000_0300);
      do_op(1'b0, 2'b11, 17'h00300, 32'h0, 0, rd);

      // Reset in the middle of a refill.
      for (int k = 0; k < 4; k++) begin
         m.addr = 17'h00700 + 17'(4 * k); m.we = 1'b0; m.sel = 2'b11; m.wdata = '0;
         mem_exp.push_back(m);
      end
      start_acks = ack_cnt;
      cpu_we = 1'b0; cpu_sel = 2'b11; cpu_addr = 17'h00700; cpu_req = 1'b1;
      n = 0;
      while (ack_cnt - start_acks < 2 && n < 100) begin
         @(posedge clk); #2;
         n++;
      end
      check("rst_wait_acks", ack_cnt - start_acks, 2);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      check("midrst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      cpu_req = 1'b0;
      mem_exp.delete();
      model_clear();
      m_pend = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("midrst_mem_addr", {15'd0, mem_addr}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(1'b0, 2'b11, 17'h00700, 32'h0, 0, rd);
      check("t7_refill", rd, 32'hA000_0700);

      for (int i = 0; i < 150; i++) begin
         a   = 17'(($urandom % 4) << 10) | 17'(($urandom % 4) << 4) | 17'($urandom % 16);
         we  = ($urandom % 3) == 0;
         sel = we ? 2'(1 + $urandom % 3) : 2'b11;
         do_op(we, sel, a, $urandom, 0, rd);
         if (i % 37 == 36) pulse_flush();
      end

      repeat (4) @(posedge clk);
      check("mem_exp_empty", mem_exp.size(), 0);
      check("resp_exp_empty", resp_exp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dcache_dm.md
Name: dcache_dm

Overview:
- Parametrised direct-mapped data cache between the MEM stage and the memory/arbiter port.
- Caches multi-word lines. Write-through, no-write-allocate.
- Byte/half/word writes use the existing 2-bit select encoding.
- Read misses trigger a line refill through a req/ack memory handshake; a flush input invalidates all lines.

Parameters:
- ADDR_WIDTH, 17, byte-address width.
- INDEX_BITS, 6, log2 of the number of lines.
- LINE_WORDS, 4, 32-bit words per line (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  request valid; held stable until cpu_ready
- cpu_we  in  1  1=write, 0=read
- cpu_sel  in  2  01 byte, 10 half, 11 word
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  32  write data, right-aligned
- cpu_rdata  out  32  aligned word containing cpu_addr
- cpu_ready  out  1  one-cycle completion pulse
- flush  in  1  pulse: invalidate all lines
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_sel  out  2  select for writes; 11 on refill reads
- mem_addr  out  ADDR_WIDTH  byte address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid with mem_ack
- mem_ack  in  1  one-cycle completion of current mem access

Behaviour:
- Address split: offset = 2+log2(LINE_WORDS) LSBs; index = next INDEX_BITS bits; tag = rest. Storage: valid bit, tag and data per line.
- Reset: all valid=0, state IDLE, pending_flush=0; all outputs 0. Reset mid-operation aborts at once: mem_req drops asynchronously and the partially filled line stays invalid.
- States: IDLE, REFILL, WRITE, RESP.
- IDLE, flush=1 or pending_flush=1: clear all valid in that cycle. Priority over cpu_req; the request is evaluated next cycle.
- IDLE, read hit: go to RESP.
- IDLE, read miss: go to REFILL, beat counter=0.
- IDLE, write: go to WRITE.
- REFILL:
  - mem_req=1, mem_we=0, mem_sel=11, mem_addr = line base + 4*beat.
  - Each mem_ack writes mem_rdata into word[beat] and increments beat.
  - On the ack of the last beat: set valid, store tag, go to RESP.
  - Beats are always issued word 0 upward, not critical-word-first.
- WRITE:
  - mem_req=1, mem_we=1, mem_sel=cpu_sel, mem_addr=cpu_addr, mem_wdata=cpu_wdata.
  - On mem_ack: if hit, merge the bytes into the cached word and go to RESP.
  - Lane merge: byte goes to lane addr[1:0], half to lanes {addr[1],0}+0/+1, word to all lanes.
  - Miss: no line update.
- RESP: cpu_ready=1 for exactly one cycle. For reads, cpu_rdata = cached word at addr[offset:2]; it holds until the next RESP. Return to IDLE; cpu_req is ignored in this cycle.
- Hit latency: cpu_ready 1 cycle after the request is seen in IDLE. Miss latency: LINE_WORDS acks + 1 cycle.
- Misalignment: word ignores addr[1:0]; half ignores addr[0]. No error reported.
- mem_ack while mem_req=0: ignored.
- flush outside IDLE: sets pending_flush, consumed on the next IDLE cycle. A line refilled in the same transaction is therefore invalidated after its response.
- mem_req/mem_we/mem_addr/mem_sel are registered and stable from assertion to ack.

Test Plan:
- Defaults (line 16 B, index = addr[9:4], tag = addr[16:10]); memory model returns 0xA0000000|addr with 2-cycle ack.
- After reset, read 0x00104: 4 mem reads at 0x00100/104/108/10C, then cpu_rdata=0xA0000104 with cpu_ready one cycle after the 4th ack. Re-read 0x00104: cpu_ready 1 cycle later, mem_req stays 0.
- Write byte 0x00105, wdata 0xEE, sel 01: mem write addr 0x00105, sel 01. Then read 0x00104: hit returning 0xA000EE04.
- Read 0x00504 (same index, different tag): refill replaces the line. Then read 0x00104: full 4-beat refill again.
- Word write miss to 0x00200: single mem write, no refill. Following read of 0x00200: miss with 4 beats.
- flush pulsed during REFILL of 0x00300: response completes normally; the next read of 0x00300 misses.
- rst asserted after 2 acks of a refill: mem_req=0 and cpu_ready=0 immediately. After release, a read of the same address performs a full 4-beat refill.
